// File: rtl/ifetch_ctrl.sv
// Instruction fetch and run control ahead of the PC: imem, branch LUT, start/done handshake.
// Optional breakpoint support is compiled in with IFETCH_BREAKPOINT_EN.
module ifetch_ctrl #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [4:0]  HALT_OP    = 5'b11111,
  parameter logic [4:0]  NOP_OP     = 5'b00000,
  parameter logic [15:0] MAX_CYCLES = 16'd4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc_i,
  input  logic        start,
  input  logic        load_we,
  input  logic [7:0]  load_addr,
  input  logic [8:0]  load_data,
  input  logic        lut_we,
  input  logic [3:0]  lut_addr,
  input  logic [14:0] lut_data,
`ifdef IFETCH_BREAKPOINT_EN
  input  logic        bp_we,
  input  logic [7:0]  bp_addr,
  input  logic        bp_en,
  output logic        bp_hit_o,
`endif
  output logic [8:0]  instr_o,
  output logic [4:0]  op_o,
  output logic [14:0] bamt_o,
  output logic        cpu_reset_o,
  output logic        running_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] cycle_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [8:0]  imem [IMEM_DEPTH];
  logic [14:0] lut  [16];
  logic        halt_hit;
  logic        tmo_hit;
  logic        bp_stop;

  // Memories are not reset; writes are locked out while a program runs.
  always_ff @(posedge clk) begin
    if (load_we && state != S_RUN) imem[load_addr] <= load_data;
    if (lut_we && state != S_RUN)   lut[lut_addr]   <= lut_data;
  end

  always_comb begin
    instr_o = {NOP_OP, 4'b0000};
    if (state == S_RUN) instr_o = imem[pc_i];
  end

  assign op_o     = instr_o[8:4];
  assign bamt_o   = lut[instr_o[3:0]];
  assign halt_hit = (op_o == HALT_OP);
  assign tmo_hit  = (cycle_count_o == MAX_CYCLES - 16'd1);

`ifdef IFETCH_BREAKPOINT_EN
  logic [7:0] bp_addr_q;

  always_ff @(posedge clk) begin
    if (bp_we && state != S_RUN) bp_addr_q <= bp_addr;
  end

  assign bp_stop = bp_en && (pc_i == bp_addr_q);
`else
  assign bp_stop = 1'b0;
`endif

  // running_o / cpu_reset_o are registered alongside state so they match its decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      running_o     <= 1'b0;
      cpu_reset_o   <= 1'b1;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      cycle_count_o <= '0;
`ifdef IFETCH_BREAKPOINT_EN
      bp_hit_o      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            running_o     <= 1'b1;
            cpu_reset_o   <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
            cycle_count_o <= '0;
`ifdef IFETCH_BREAKPOINT_EN
            bp_hit_o      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          cycle_count_o <= cycle_count_o + 16'd1;
          if (halt_hit || bp_stop || tmo_hit) begin
            state       <= S_DONE;
            running_o   <= 1'b0;
            cpu_reset_o <= 1'b1;
            done_o      <= 1'b1;
            timeout_o   <= !halt_hit && !bp_stop;
`ifdef IFETCH_BREAKPOINT_EN
            bp_hit_o    <= !halt_hit && bp_stop;
`endif
          end
        end
        default: begin
          state       <= S_IDLE;
          running_o   <= 1'b0;
          cpu_reset_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a model of the run rules predicts fetches and run results.
module tb_ifetch_ctrl;
  localparam logic [15:0] TB_MAX = 16'd10;
  localparam logic [4:0]  HALT = 5'b11111;
  localparam logic [4:0]  NOP  = 5'b00000;
  localparam logic [4:0]  BA   = 5'b00001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pc_i = '0;
  logic        start = 1'b0;
  logic        load_we = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [8:0]  load_data = '0;
  logic        lut_we = 1'b0;
  logic [3:0]  lut_addr = '0;
  logic [14:0] lut_data = '0;
  logic [8:0]  instr_o;
  logic [4:0]  op_o;
  logic [14:0] bamt_o;
  logic        cpu_reset_o, running_o, done_o, timeout_o;
  logic [15:0] cycle_count_o;
`ifdef IFETCH_BREAKPOINT_EN
  logic        bp_we = 1'b0;
  logic [7:0]  bp_addr = '0;
  logic        bp_en = 1'b0;
  logic        bp_hit_o;
`endif

  ifetch_ctrl #(
    .IMEM_DEPTH(256),
    .HALT_OP(HALT),
    .NOP_OP(NOP),
    .MAX_CYCLES(TB_MAX)
  ) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .start(start),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
`ifdef IFETCH_BREAKPOINT_EN
    .bp_we(bp_we), .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit_o(bp_hit_o),
`endif
    .instr_o(instr_o), .op_o(op_o), .bamt_o(bamt_o), .cpu_reset_o(cpu_reset_o),
    .running_o(running_o), .done_o(done_o), .timeout_o(timeout_o),
    .cycle_count_o(cycle_count_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: memory images plus run status as seen after each clock edge.
  typedef struct { logic [8:0] instr; logic [14:0] bamt; } fetch_t;
  typedef struct { int unsigned cnt; bit to; bit bp; } res_t;

  logic [8:0]  m_imem [256];
  logic [14:0] m_lut  [16];
  int          m_st = 0;          // 0 idle, 1 running, 2 done
  int unsigned m_cnt = 0;
  bit          m_to = 1'b0;
  bit          m_bp = 1'b0;
  logic [7:0]  m_bpa = '0;
  bit          mon_en = 1'b0;
  bit          lut_loaded = 1'b0;
  fetch_t      fq[$];
  res_t        rq[$];

  // Advance one clock: predict this cycle's fetch and next status, then apply writes after the edge.
  task automatic cycle();
    int          nst;
    int unsigned ncnt;
    bit          nto, nbp, wi, wl, wb;
    logic [8:0]  w;
    logic [7:0]  wia, wba;
    logic [8:0]  wid;
    logic [3:0]  wla;
    logic [14:0] wld;
    fetch_t      f;
    res_t        r;
    nst = m_st; ncnt = m_cnt; nto = m_to; nbp = m_bp;
    w = {NOP, 4'h0};
    if (m_st == 1) begin
      w = m_imem[pc_i];
      f.instr = w; f.bamt = m_lut[w[3:0]];
      fq.push_back(f);
    end
    wi = load_we && m_st != 1; wia = load_addr; wid = load_data;
    wl = lut_we && m_st != 1;  wla = lut_addr;  wld = lut_data;
    wb = 1'b0; wba = '0;
`ifdef IFETCH_BREAKPOINT_EN
    wb = bp_we && m_st != 1; wba = bp_addr;
`endif
    if (reset) begin
      nst = 0; ncnt = 0; nto = 0; nbp = 0;
    end else if (m_st != 1) begin
      if (start) begin nst = 1; ncnt = 0; nto = 0; nbp = 0; end
    end else begin
      ncnt = m_cnt + 1;
      if (w[8:4] == HALT) begin nst = 2; nto = 0; end
`ifdef IFETCH_BREAKPOINT_EN
      else if (bp_en && pc_i == m_bpa) begin nst = 2; nbp = 1; end
`endif
      else if (m_cnt == int'(TB_MAX) - 1) begin nst = 2; nto = 1; end
      if (nst == 2) begin
        r.cnt = ncnt; r.to = nto; r.bp = nbp;
        rq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    if (wi) m_imem[wia] = wid;
    if (wl) m_lut[wla] = wld;
    if (wb) m_bpa = wba;
    m_st = nst; m_cnt = ncnt; m_to = nto; m_bp = nbp;
  endtask

  fetch_t mf;
  res_t   mr;
  bit     done_q = 1'b0;

  // Monitor: status every cycle, a fetch pop on each running cycle, a result pop on done rising.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("running", 32'(running_o), 32'(m_st == 1));
      chk("cpu_reset", 32'(cpu_reset_o), 32'(m_st != 1));
      chk("done", 32'(done_o), 32'(m_st == 2));
      chk("timeout", 32'(timeout_o), 32'(m_to));
      chk("cycle_count", 32'(cycle_count_o), m_cnt);
`ifdef IFETCH_BREAKPOINT_EN
      chk("bp_hit", 32'(bp_hit_o), 32'(m_bp));
`endif
      if (running_o) begin
        if (fq.size() == 0) begin
          n_checks++;
          $display("FAIL fetch_queue: DUT running with no expected fetch at %0t", $time);
        end else begin
          mf = fq.pop_front();
          chk("instr_run", 32'(instr_o), 32'(mf.instr));
          chk("op_run", 32'(op_o), 32'(mf.instr[8:4]));
          chk("bamt_run", 32'(bamt_o), 32'(mf.bamt));
        end
      end else begin
        chk("instr_idle", 32'(instr_o), 32'({NOP, 4'h0}));
        chk("op_idle", 32'(op_o), 32'(NOP));
        if (lut_loaded) chk("bamt_idle", 32'(bamt_o), 32'(m_lut[0]));
      end
      if (done_o && !done_q) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL result_queue: done rose with no expected result at %0t", $time);
        end else begin
          mr = rq.pop_front();
          chk("res_count", 32'(cycle_count_o), mr.cnt);
          chk("res_timeout", 32'(timeout_o), 32'(mr.to));
`ifdef IFETCH_BREAKPOINT_EN
          chk("res_bp", 32'(bp_hit_o), 32'(mr.bp));
`endif
        end
      end
      done_q = done_o;
    end
  end

  function automatic logic [8:0] rand_word();
    logic [4:0] op;
    op = ($urandom_range(0, 5) == 0) ? HALT : 5'($urandom);
    return {op, 4'($urandom)};
  endfunction

  task automatic wr_imem(input logic [7:0] a, input logic [8:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    cycle();
    load_we = 1'b0;
  endtask

  task automatic wr_lut(input logic [3:0] a, input logic [14:0] d);
    lut_we = 1'b1; lut_addr = a; lut_data = d;
    cycle();
    lut_we = 1'b0;
  endtask

  // wr_mode: 0 no writes, 1 random writes (incl. with start), 2 try to overwrite imem[1] with HALT mid-run.
  task automatic run(input bit inc, input int rst_at, input int wr_mode);
    start = 1'b1;
    pc_i = 8'($urandom);
    if (wr_mode == 1) begin
      load_we = 1'b1; load_addr = inc ? 8'h00 : 8'($urandom); load_data = rand_word();
      lut_we = 1'b1; lut_addr = 4'($urandom); lut_data = 15'($urandom);
    end
    cycle();
    start = 1'b0; load_we = 1'b0; lut_we = 1'b0;
    for (int k = 0; k < int'(TB_MAX) + 2 && m_st == 1; k++) begin
      pc_i  = inc ? 8'(k) : 8'($urandom);
      start = ($urandom_range(0, 7) == 0);
      reset = (k == rst_at);
      load_we = 1'b0; lut_we = 1'b0;
      if (wr_mode == 1) begin
        load_we = 1'($urandom); load_addr = 8'($urandom); load_data = rand_word();
        lut_we = 1'($urandom); lut_addr = 4'($urandom); lut_data = 15'($urandom);
      end else if (wr_mode == 2 && k == 0) begin
        load_we = 1'b1; load_addr = 8'h01; load_data = {HALT, 4'h0};
      end
      cycle();
    end
    start = 1'b0; reset = 1'b0; load_we = 1'b0; lut_we = 1'b0;
    pc_i = 8'($urandom);
    cycle();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_imem[i] = '0;
    for (int i = 0; i < 16; i++) m_lut[i] = '0;
    reset = 1'b1;
    cycle();
    mon_en = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset_count", 32'(cycle_count_o), 32'd0);
    chk("reset_cpu_reset", 32'(cpu_reset_o), 32'd1);

    for (int i = 0; i < 256; i++) begin
      load_we = 1'b1; load_addr = 8'(i); load_data = rand_word();
      lut_we = (i < 16); lut_addr = 4'(i); lut_data = 15'($urandom);
      cycle();
    end
    load_we = 1'b0; lut_we = 1'b0;
    lut_loaded = 1'b1;

    // NOP, NOP, HALT with an incrementing PC
    wr_imem(8'd0, {NOP, 4'h0});
    wr_imem(8'd1, {NOP, 4'h0});
    wr_imem(8'd2, {HALT, 4'h0});
    run(1'b1, -1, 0);
    chk("t1_count", 32'(cycle_count_o), 32'd3);
    chk("t1_timeout", 32'(timeout_o), 32'd0);
    chk("t1_done", 32'(done_o), 32'd1);

    // branch op with LUT offset on the first RUN cycle
    wr_imem(8'd0, {BA, 4'd2});
    wr_lut(4'd2, 15'd5);
    run(1'b1, -1, 0);

    // no HALT within reach: timeout, then HALT exactly on the last allowed cycle
    for (int i = 0; i < 16; i++) wr_imem(8'(i), {5'b00010, 4'(i)});
    run(1'b1, -1, 0);
    chk("t3_count", 32'(cycle_count_o), 32'(TB_MAX));
    chk("t3_timeout", 32'(timeout_o), 32'd1);
    wr_imem(8'(TB_MAX - 16'd1), {HALT, 4'h3});
    run(1'b1, -1, 0);
    chk("t3b_count", 32'(cycle_count_o), 32'(TB_MAX));
    chk("t3b_timeout", 32'(timeout_o), 32'd0);

    // write attempted during RUN is dropped; rerun still fetches the original word
    wr_imem(8'd1, {5'b00011, 4'h1});
    run(1'b1, -1, 2);
    run(1'b1, -1, 0);

    // reset in the 4th RUN cycle, then a normal run
    run(1'b1, 3, 0);
    chk("t5_count", 32'(cycle_count_o), 32'd0);
    chk("t5_done", 32'(done_o), 32'd0);
    chk("t5_cpu_reset", 32'(cpu_reset_o), 32'd1);
    run(1'b1, -1, 0);

`ifdef IFETCH_BREAKPOINT_EN
    for (int i = 0; i < 4; i++) wr_imem(8'(i), {5'b00010, 4'(i)});
    bp_we = 1'b1; bp_addr = 8'd1;
    cycle();
    bp_we = 1'b0; bp_en = 1'b1;
    run(1'b1, -1, 0);
    chk("t6_bp_hit", 32'(bp_hit_o), 32'd1);
    chk("t6_count", 32'(cycle_count_o), 32'd2);
    bp_en = 1'b0;
`endif

    for (int n = 0; n < 60; n++) begin
`ifdef IFETCH_BREAKPOINT_EN
      bp_we = 1'b1; bp_addr = 8'($urandom_range(0, 12));
      cycle();
      bp_we = 1'b0; bp_en = ($urandom_range(0, 3) == 0);
`endif
      run(1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1,
          int'($urandom_range(0, 1)));
    end

    chk("fetch_queue_drained", fq.size(), 32'd0);
    chk("result_queue_drained", rq.size(), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
